cvxif_copro_responder: RTL and testbench



---
 rtl/cvxif_copro_pkg.sv | 41 ++++
 rtl/cvxif_copro_decoder.sv | 52 +++++
 rtl/cvxif_copro_responder.sv | 238 +++++++++++++++++++++++
 tb/tb_cvxif_copro_responder.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cvxif_copro_pkg.sv
// Shared types and constants for the CV-X-IF reference coprocessor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cvxif_copro_pkg;

    // Storage widths of a pending entry; the responder's XLEN/IdWidth defaults track these.
    localparam int unsigned CoproXlen    = 64;
    localparam int unsigned CoproIdWidth = 3;

    // Width of the execute down-counter (MultiLatency is at most 15).
    localparam int unsigned LatCntWidth  = 4;

    localparam logic [6:0] OpcodeCustom3  = 7'b1111011;
    localparam logic [6:0] Funct7Add      = 7'b0000000;
    localparam logic [6:0] Funct7Nop      = 7'b0000001;
    localparam logic [6:0] Funct7AddMulti = 7'b0000010;
    localparam logic [2:0] Funct3Cus      = 3'b000;

    typedef enum logic [1:0] {
        OP_ADD,
        OP_NOP,
        OP_ADD_MULTI
    } op_e;

    typedef struct packed {
        logic [CoproIdWidth-1:0] id;
        logic [4:0]              rd;
        logic [CoproXlen-1:0]    rs1;
        logic [CoproXlen-1:0]    rs2;
        op_e                     op;
        logic                    committed;
        logic                    killed;
    } pending_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_RESULT
    } fsm_state_e;

endpackage

// File: rtl/cvxif_copro_decoder.sv
// Decodes a custom-3 instruction word into accept/writeback/op/rd.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller gates the outputs with its own handshake.
// Ports: instr_i (32b word) -> accept_o, writeback_o, op_o, rd_o (rd forced to 0 for NOP).
// CUS_ADD_MULTI is decoded only when CVXIF_COPRO_MULTICYCLE_EN is defined.
module cvxif_copro_decoder
    import cvxif_copro_pkg::*;
(
    input  logic [31:0] instr_i,
    output logic        accept_o,
    output logic        writeback_o,
    output op_e         op_o,
    output logic [4:0]  rd_o
);

    // Source register fields are not needed: operands arrive on the issue bus.
    logic unused_instr_bits;
    assign unused_instr_bits = ^instr_i[24:15];

    always_comb begin
        accept_o    = 1'b0;
        writeback_o = 1'b0;
        op_o        = OP_NOP;
        rd_o        = 5'd0;
        if ((instr_i[6:0] == OpcodeCustom3) && (instr_i[14:12] == Funct3Cus)) begin
            case (instr_i[31:25])
                Funct7Add: begin
                    accept_o    = 1'b1;
                    writeback_o = 1'b1;
                    op_o        = OP_ADD;
                    rd_o        = instr_i[11:7];
                end
                Funct7Nop: begin
                    accept_o    = 1'b1;
                    op_o        = OP_NOP;
                end
`ifdef CVXIF_COPRO_MULTICYCLE_EN
                Funct7AddMulti: begin
                    accept_o    = 1'b1;
                    writeback_o = 1'b1;
                    op_o        = OP_ADD_MULTI;
                    rd_o        = instr_i[11:7];
                end
`endif
                default: begin
                    accept_o = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/cvxif_copro_responder.sv
// CV-X-IF responder: accepts custom-3 ops, buffers them in order, executes after commit.
// Latency: commit to result_valid_o is 2 cycles (ADD/NOP), MultiLatency+1 (ADD_MULTI).
// Backpressure: issue_ready_o drops when the pending buffer is full; results hold until result_ready_i.
// Ports: clk_i/rst_ni; issue channel (valid/ready/instr/id/rs1/rs2 -> accept/writeback);
//        commit channel (valid/id/kill); result channel (valid/ready/id/data/rd/we).
// Optional: CVXIF_COPRO_MULTICYCLE_EN enables CUS_ADD_MULTI and the execute counter.
module cvxif_copro_responder
    import cvxif_copro_pkg::*;
#(
    parameter int unsigned XLEN         = CoproXlen,
    parameter int unsigned IdWidth      = CoproIdWidth,
    parameter int unsigned NrEntries    = 4,
    parameter int unsigned MultiLatency = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               issue_valid_i,
    output logic               issue_ready_o,
    input  logic [31:0]        issue_instr_i,
    input  logic [IdWidth-1:0] issue_id_i,
    input  logic [XLEN-1:0]    issue_rs1_i,
    input  logic [XLEN-1:0]    issue_rs2_i,
    output logic               issue_accept_o,
    output logic               issue_writeback_o,
    input  logic               commit_valid_i,
    input  logic [IdWidth-1:0] commit_id_i,
    input  logic               commit_kill_i,
    output logic               result_valid_o,
    input  logic               result_ready_i,
    output logic [IdWidth-1:0] result_id_o,
    output logic [XLEN-1:0]    result_data_o,
    output logic [4:0]         result_rd_o,
    output logic               result_we_o
);

    localparam int unsigned PtrW = $clog2(NrEntries);
    localparam int unsigned CntW = $clog2(NrEntries + 1);

    pending_entry_t       entry_q [NrEntries];
    pending_entry_t       entry_d [NrEntries];
    logic [NrEntries-1:0] vld_q, vld_d;
    logic [PtrW-1:0]      head_q, head_d;
    logic [PtrW-1:0]      tail_q, tail_d;
    logic [CntW-1:0]      count_q, count_d;
    fsm_state_e           state_q, state_d;

    logic                 res_vld_q, res_vld_d;
    logic [IdWidth-1:0]   res_id_q, res_id_d;
    logic [XLEN-1:0]      res_dat_q, res_dat_d;
    logic [4:0]           res_rd_q, res_rd_d;
    logic                 res_we_q, res_we_d;

`ifdef CVXIF_COPRO_MULTICYCLE_EN
    logic [LatCntWidth-1:0] cnt_q, cnt_d;
`else
    localparam int unsigned unused_multi_latency = MultiLatency;
`endif

    logic           dec_accept;
    logic           dec_writeback;
    op_e            dec_op;
    logic [4:0]     dec_rd;

    logic           full;
    logic           push;
    logic           pop;
    logic           exec_done;
    pending_entry_t head_e;
    logic           head_hit;
    logic           head_go;
    logic           head_kill;

    cvxif_copro_decoder u_decoder (
        .instr_i     (issue_instr_i),
        .accept_o    (dec_accept),
        .writeback_o (dec_writeback),
        .op_o        (dec_op),
        .rd_o        (dec_rd)
    );

    // Ready comes from the registered count, so a full buffer never pushes even if it pops.
    assign full              = (count_q == CntW'(NrEntries));
    assign issue_ready_o     = !full;
    assign push              = issue_valid_i && !full && dec_accept;
    assign issue_accept_o    = push;
    assign issue_writeback_o = push && dec_writeback;

    // A commit arriving this cycle for the head is honoured immediately, which is
    // what gives the 2-cycle commit-to-result latency for single-cycle ops.
    assign head_e    = entry_q[head_q];
    assign head_hit  = commit_valid_i && (head_e.id == commit_id_i);
    assign head_go   = head_e.committed || (head_hit && !commit_kill_i);
    assign head_kill = head_e.killed    || (head_hit &&  commit_kill_i);

    assign result_valid_o = res_vld_q;
    assign result_id_o    = res_id_q;
    assign result_data_o  = res_dat_q;
    assign result_rd_o    = res_rd_q;
    assign result_we_o    = res_we_q;

    always_comb begin
        entry_d   = entry_q;
        vld_d     = vld_q;
        head_d    = head_q;
        tail_d    = tail_q;
        state_d   = state_q;
        res_vld_d = res_vld_q;
        res_id_d  = res_id_q;
        res_dat_d = res_dat_q;
        res_rd_d  = res_rd_q;
        res_we_d  = res_we_q;
        pop       = 1'b0;
        exec_done = 1'b0;
`ifdef CVXIF_COPRO_MULTICYCLE_EN
        cnt_d     = cnt_q;
`endif

        // Commit decisions tag any buffered entry with a matching id; no match is a no-op.
        if (commit_valid_i) begin
            for (int i = 0; i < NrEntries; i++) begin
                if (vld_q[i] && (entry_q[i].id == commit_id_i)) begin
                    if (commit_kill_i) begin
                        entry_d[i].killed = 1'b1;
                    end else begin
                        entry_d[i].committed = 1'b1;
                    end
                end
            end
        end

        unique case (state_q)
            ST_IDLE: begin
                if (count_q != '0) begin
                    if (head_kill) begin
                        pop = 1'b1;
                    end else if (head_go) begin
                        state_d = ST_EXEC;
`ifdef CVXIF_COPRO_MULTICYCLE_EN
                        cnt_d = (head_e.op == OP_ADD_MULTI) ?
                                LatCntWidth'(MultiLatency - 1) : '0;
`endif
                    end
                end
            end
            ST_EXEC: begin
`ifdef CVXIF_COPRO_MULTICYCLE_EN
                exec_done = (cnt_q == '0);
                if (!exec_done) begin
                    cnt_d = cnt_q - LatCntWidth'(1);
                end
`else
                exec_done = 1'b1;
`endif
                if (exec_done) begin
                    res_vld_d = 1'b1;
                    res_id_d  = head_e.id;
                    res_dat_d = head_e.rs1 + head_e.rs2;
                    res_rd_d  = head_e.rd;
                    res_we_d  = (head_e.op != OP_NOP);
                    state_d   = ST_RESULT;
                end
            end
            ST_RESULT: begin
                if (result_ready_i) begin
                    pop       = 1'b1;
                    res_vld_d = 1'b0;
                    res_id_d  = '0;
                    res_dat_d = '0;
                    res_rd_d  = '0;
                    res_we_d  = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (pop) begin
            vld_d[head_q] = 1'b0;
            head_d        = head_q + PtrW'(1);
        end

        if (push) begin
            entry_d[tail_q].id        = issue_id_i;
            entry_d[tail_q].rd        = dec_rd;
            entry_d[tail_q].rs1       = issue_rs1_i;
            entry_d[tail_q].rs2       = issue_rs2_i;
            entry_d[tail_q].op        = dec_op;
            // A commit for the instruction being issued this very cycle is kept, not lost.
            entry_d[tail_q].committed = commit_valid_i && !commit_kill_i &&
                                        (commit_id_i == issue_id_i);
            entry_d[tail_q].killed    = commit_valid_i &&  commit_kill_i &&
                                        (commit_id_i == issue_id_i);
            vld_d[tail_q]             = 1'b1;
            tail_d                    = tail_q + PtrW'(1);
        end

        count_d = count_q + CntW'(push) - CntW'(pop);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NrEntries; i++) begin
                entry_q[i] <= '0;
            end
            vld_q     <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            state_q   <= ST_IDLE;
            res_vld_q <= 1'b0;
            res_id_q  <= '0;
            res_dat_q <= '0;
            res_rd_q  <= '0;
            res_we_q  <= 1'b0;
`ifdef CVXIF_COPRO_MULTICYCLE_EN
            cnt_q     <= '0;
`endif
        end else begin
            entry_q   <= entry_d;
            vld_q     <= vld_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            state_q   <= state_d;
            res_vld_q <= res_vld_d;
            res_id_q  <= res_id_d;
            res_dat_q <= res_dat_d;
            res_rd_q  <= res_rd_d;
            res_we_q  <= res_we_d;
`ifdef CVXIF_COPRO_MULTICYCLE_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_cvxif_copro_responder.sv
// Self-checking bench for cvxif_copro_responder: directed stimulus, queue-based reference model.
// Latency: n/a.
// Backpressure: drives result_ready_i low in one phase to exercise result holding.
module tb_cvxif_copro_responder;

    localparam int NR = 4;
    localparam int ML = 4;
    localparam logic [6:0] OPC = 7'b1111011;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        issue_valid_i = 1'b0;
    logic        issue_ready_o;
    logic [31:0] issue_instr_i = '0;
    logic [2:0]  issue_id_i = '0;
    logic [63:0] issue_rs1_i = '0;
    logic [63:0] issue_rs2_i = '0;
    logic        issue_accept_o;
    logic        issue_writeback_o;
    logic        commit_valid_i = 1'b0;
    logic [2:0]  commit_id_i = '0;
    logic        commit_kill_i = 1'b0;
    logic        result_valid_o;
    logic        result_ready_i = 1'b1;
    logic [2:0]  result_id_o;
    logic [63:0] result_data_o;
    logic [4:0]  result_rd_o;
    logic        result_we_o;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    cvxif_copro_responder #(
        .XLEN(64), .IdWidth(3), .NrEntries(NR), .MultiLatency(ML)
    ) dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .issue_valid_i     (issue_valid_i),
        .issue_ready_o     (issue_ready_o),
        .issue_instr_i     (issue_instr_i),
        .issue_id_i        (issue_id_i),
        .issue_rs1_i       (issue_rs1_i),
        .issue_rs2_i       (issue_rs2_i),
        .issue_accept_o    (issue_accept_o),
        .issue_writeback_o (issue_writeback_o),
        .commit_valid_i    (commit_valid_i),
        .commit_id_i       (commit_id_i),
        .commit_kill_i     (commit_kill_i),
        .result_valid_o    (result_valid_o),
        .result_ready_i    (result_ready_i),
        .result_id_o       (result_id_o),
        .result_data_o     (result_data_o),
        .result_rd_o       (result_rd_o),
        .result_we_o       (result_we_o)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [2:0]  id;
        logic [4:0]  rd;
        logic [63:0] dat;
        bit          we;
        int          lat;
        bit          committed;
        bit          killed;
    } mentry_t;

    mentry_t mq[$];
    int      res_at = -1;   // cycle index at which the head's result is visible
    int      cyc = 0;

    function automatic void tb_decode(input logic [31:0] ins, output bit acc, output bit wb,
                                      output int lat, output logic [4:0] rd);
        acc = 0; wb = 0; lat = 2; rd = 5'd0;
        if (ins[6:0] == OPC && ins[14:12] == 3'b000) begin
            case (ins[31:25])
                7'd0: begin acc = 1; wb = 1; rd = ins[11:7]; end
                7'd1: begin acc = 1; end
`ifdef CVXIF_COPRO_MULTICYCLE_EN
                7'd2: begin acc = 1; wb = 1; rd = ins[11:7]; lat = ML + 1; end
`endif
                default: ;
            endcase
        end
    endfunction

    always @(posedge clk_i) begin
        bit          full_m, acc, wb;
        int          lat;
        logic [4:0]  rd;
        mentry_t     e;
        full_m = (mq.size() >= NR);
        if (!rst_ni) begin
            mq.delete();
            res_at = -1;
        end else begin
            if (commit_valid_i) begin
                foreach (mq[i]) begin
                    if (mq[i].id == commit_id_i) begin
                        if (commit_kill_i) mq[i].killed = 1;
                        else               mq[i].committed = 1;
                    end
                end
            end
            if (res_at >= 0) begin
                if (cyc >= res_at && result_ready_i) begin
                    void'(mq.pop_front());
                    res_at = -1;
                end
            end else if (mq.size() > 0) begin
                if (mq[0].killed)         void'(mq.pop_front());
                else if (mq[0].committed) res_at = cyc + mq[0].lat;
            end
            if (issue_valid_i && !full_m) begin
                tb_decode(issue_instr_i, acc, wb, lat, rd);
                if (acc) begin
                    e.id        = issue_id_i;
                    e.rd        = rd;
                    e.dat       = issue_rs1_i + issue_rs2_i;
                    e.we        = wb;
                    e.lat       = lat;
                    e.committed = commit_valid_i && !commit_kill_i && (commit_id_i == issue_id_i);
                    e.killed    = commit_valid_i &&  commit_kill_i && (commit_id_i == issue_id_i);
                    mq.push_back(e);
                end
            end
        end
        cyc++;
    end

    always @(negedge clk_i) begin
        bit         ev, acc, wb;
        int         lat;
        logic [4:0] rd;
        if (rst_ni) begin
            ev = (res_at >= 0) && (cyc >= res_at);
            chk("m_result_valid", result_valid_o, ev);
            if (ev) begin
                chk("m_result_id", result_id_o, mq[0].id);
                chk("m_result_we", result_we_o, mq[0].we);
                chk("m_result_rd", result_rd_o, mq[0].rd);
                if (mq[0].we) chk("m_result_data", result_data_o, mq[0].dat);
            end
            chk("m_issue_ready", issue_ready_o, mq.size() < NR);
            if (issue_valid_i && mq.size() < NR) begin
                tb_decode(issue_instr_i, acc, wb, lat, rd);
                chk("m_issue_accept", issue_accept_o, acc);
                chk("m_issue_writeback", issue_writeback_o, wb);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic issue(input logic [6:0] f7, input logic [6:0] opc, input logic [2:0] id,
                         input logic [4:0] rd, input logic [63:0] a, input logic [63:0] b);
        issue_valid_i = 1'b1;
        issue_instr_i = {f7, 5'd2, 5'd1, 3'b000, rd, opc};
        issue_id_i    = id;
        issue_rs1_i   = a;
        issue_rs2_i   = b;
    endtask

    task automatic no_issue();
        issue_valid_i = 1'b0;
        issue_instr_i = '0;
    endtask

    task automatic commit(input logic [2:0] id, input logic kill);
        commit_valid_i = 1'b1;
        commit_id_i    = id;
        commit_kill_i  = kill;
    endtask

    task automatic no_commit();
        commit_valid_i = 1'b0;
        commit_kill_i  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] got [4];
        int         ngot;

        // Reset state
        #2;
        chk("rst_valid", result_valid_o, 0);
        chk("rst_data", result_data_o, 0);
        chk("rst_ready", issue_ready_o, 1);
        tick(); tick();
        rst_ni = 1'b1;
        tick();

        // CUS_ADD id2: 5+7 -> x10, result exactly 2 cycles after commit
        issue(7'd0, OPC, 3'd2, 5'd10, 64'd5, 64'd7);
        #1;
        chk("add_accept", issue_accept_o, 1);
        chk("add_writeback", issue_writeback_o, 1);
        tick();
        no_issue();
        commit(3'd2, 1'b0);
        @(negedge clk_i); chk("add_lat_c0", result_valid_o, 0);
        tick(); no_commit();
        @(negedge clk_i); chk("add_lat_c1", result_valid_o, 0);
        tick();
        @(negedge clk_i);
        chk("add_lat_c2", result_valid_o, 1);
        chk("add_data", result_data_o, 64'd12);
        chk("add_rd", result_rd_o, 10);
        chk("add_we", result_we_o, 1);
        chk("add_id", result_id_o, 2);
        tick();

        // Non-custom opcode is rejected and a commit to its id is ignored
        issue(7'd0, 7'b0110011, 3'd4, 5'd3, 64'd1, 64'd1);
        #1; chk("rej_accept", issue_accept_o, 0);
        tick(); no_issue(); commit(3'd4, 1'b0);
        tick(); no_commit();
        repeat (4) tick();

        // CUS_NOP: result with we=0 and rd=0
        issue(7'd1, OPC, 3'd6, 5'd7, 64'd3, 64'd4);
        #1; chk("nop_accept", issue_accept_o, 1);
        chk("nop_writeback", issue_writeback_o, 0);
        tick(); no_issue(); commit(3'd6, 1'b0);
        tick(); no_commit();
        tick();
        @(negedge clk_i);
        chk("nop_valid", result_valid_o, 1);
        chk("nop_we", result_we_o, 0);
        chk("nop_rd", result_rd_o, 0);
        tick();

        // Kill: no result, buffer drains
        issue(7'd0, OPC, 3'd1, 5'd4, 64'd9, 64'd9);
        tick(); no_issue(); commit(3'd1, 1'b1);
        tick(); no_commit();
        repeat (5) tick();
        chk("kill_ready", issue_ready_o, 1);

        // Fill four entries, fifth offer sees ready=0
        for (int i = 0; i < 4; i++) begin
            issue(7'd0, OPC, 3'(i), 5'(i + 1), 64'(i * 16 + 1), 64'd100);
            tick();
        end
        issue(7'd0, OPC, 3'd4, 5'd5, 64'd1, 64'd1);
        #1; chk("full_ready", issue_ready_o, 0);
        chk("full_accept", issue_accept_o, 0);
        tick(); no_issue();
        result_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            commit(3'(i), 1'b0);
            tick();
        end
        no_commit();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            chk("hold_valid", result_valid_o, 1);
            chk("hold_data", result_data_o, 64'd101);
            chk("hold_id", result_id_o, 0);
            tick();
        end
        result_ready_i = 1'b1;
        ngot = 0;
        for (int k = 0; k < 40 && ngot < 4; k++) begin
            @(negedge clk_i);
            if (result_valid_o) begin
                got[ngot] = result_id_o;
                ngot++;
            end
            tick();
        end
        chk("drain_count", ngot, 4);
        for (int k = 0; k < 4; k++) begin
            if (k < ngot) chk("drain_order", got[k], k);
        end
        tick();

        // CUS_ADD_MULTI: all-ones + 1 wraps to 0
        issue(7'd2, OPC, 3'd3, 5'd9, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
`ifdef CVXIF_COPRO_MULTICYCLE_EN
        #1; chk("multi_accept", issue_accept_o, 1);
        tick(); no_issue(); commit(3'd3, 1'b0);
        tick(); no_commit();
        repeat (3) tick();
        @(negedge clk_i); chk("multi_lat_c4", result_valid_o, 0);
        tick();
        @(negedge clk_i);
        chk("multi_lat_c5", result_valid_o, 1);
        chk("multi_data", result_data_o, 64'd0);
        chk("multi_rd", result_rd_o, 9);
        tick();
`else
        #1; chk("multi_reject", issue_accept_o, 0);
        tick(); no_issue();
        repeat (3) tick();
`endif

        // Reset while the head is executing: the result is lost
        issue(7'd0, OPC, 3'd5, 5'd6, 64'd40, 64'd2);
        tick(); no_issue(); commit(3'd5, 1'b0);
        tick(); no_commit();
        rst_ni = 1'b0;
        #1;
        chk("mid_rst_valid", result_valid_o, 0);
        chk("mid_rst_data", result_data_o, 0);
        chk("mid_rst_id", result_id_o, 0);
        chk("mid_rst_rd", result_rd_o, 0);
        chk("mid_rst_we", result_we_o, 0);
        chk("mid_rst_ready", issue_ready_o, 1);
        tick(); tick();
        rst_ni = 1'b1;
        repeat (8) tick();
        chk("post_rst_valid", result_valid_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
